apb_timer: RTL

- 32-bit down-counting timer/interrupt source, an APB slave on the bus driven by the AHB-to-APB bridge, beside the UART.
- The top-level address decoder produces a select that is ANDed with PSEL. The slave sees PADDR with the upper nibble zeroed.
- Gives firmware a periodic or one-shot tick and a level interrupt.
- Zero-wait-state APB slave; no bridge changes needed.

---
 rtl/apb_timer.sv | 110 +++++++++++
 1 files changed

// File: rtl/apb_timer.sv
// apb_timer: APB slave 32-bit down-counting timer with one-shot/auto-reload tick and level irq.
// Optional 16-bit prescaler at offset 0x10 when APB_TIMER_PRESCALER_EN is defined.
module apb_timer #(
    parameter int          CNT_W    = 32,
    parameter logic [31:0] RST_LOAD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PSEL,
    input  logic [31:0] PADDR,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    input  logic [3:0]  PSTRB,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        o_irq
);
    localparam logic [CNT_W-1:0] RST_CNT = RST_LOAD[CNT_W-1:0];
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [2:0]       r_ctrl;
    logic             r_expired, r_irq;
    logic [CNT_W-1:0] r_load, r_cnt;
    logic [7:0]       w_off;
    logic             w_mapped, w_bad, w_acc, w_wr, w_ctrl_wr, w_load_wr, w_stat_wr;
    logic             w_en_eff, w_tick, w_expire, w_unused;
    logic [31:0]      w_load32, w_cnt32, w_load_new, w_psc32;

    always_comb begin
        w_load32 = '0;
        w_load32[CNT_W-1:0] = r_load;
        w_cnt32 = '0;
        w_cnt32[CNT_W-1:0] = r_cnt;
        w_load_new = w_load32;
        for (int i = 0; i < 4; i++)
            w_load_new[8*i +: 8] = PSTRB[i] ? PWDATA[8*i +: 8] : w_load32[8*i +: 8];
    end

    assign w_off = PADDR[7:0];
`ifdef APB_TIMER_PRESCALER_EN
    assign w_mapped = (w_off[7:4] == 4'h0) || (w_off == 8'h10);
`else
    assign w_mapped = w_off[7:4] == 4'h0;
`endif
    assign w_bad     = !w_mapped || (w_off[1:0] != 2'b00) || (PWRITE && w_off == 8'h08);
    assign w_acc     = PSEL && PENABLE;
    assign w_wr      = w_acc && PWRITE && !w_bad;
    assign w_ctrl_wr = w_wr && w_off == 8'h00 && PSTRB[0];
    assign w_load_wr = w_wr && w_off == 8'h04;
    assign w_stat_wr = w_wr && w_off == 8'h0C && PSTRB[0] && PWDATA[0];
    // A CTRL write can stop the counter in the same cycle but only starts it on the next one
    assign w_en_eff  = w_ctrl_wr ? (r_ctrl[0] && PWDATA[0]) : r_ctrl[0];
    assign w_expire  = w_tick && r_cnt == '0;

`ifdef APB_TIMER_PRESCALER_EN
    logic [15:0] r_psc, r_pcnt;
    logic        w_psc_wr;
    assign w_psc_wr = w_wr && w_off == 8'h10;
    assign w_tick   = w_en_eff && r_pcnt == r_psc;
    assign w_psc32  = {16'h0, r_psc};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_psc  <= '0;
            r_pcnt <= '0;
        end else begin
            if (w_psc_wr)
                r_psc <= {PSTRB[1] ? PWDATA[15:8] : r_psc[15:8], PSTRB[0] ? PWDATA[7:0] : r_psc[7:0]};
            r_pcnt <= (!r_ctrl[0] || w_psc_wr || r_pcnt == r_psc) ? 16'd0 : r_pcnt + 16'd1;
        end
    end
`else
    assign w_tick  = w_en_eff;
    assign w_psc32 = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl    <= '0;
            r_expired <= 1'b0;
            r_irq     <= 1'b0;
            r_load    <= RST_CNT;
            r_cnt     <= RST_CNT;
        end else begin
            if (w_ctrl_wr)
                r_ctrl <= PWDATA[2:0];
            if (w_expire && !r_ctrl[2])
                r_ctrl[0] <= 1'b0;
            if (w_load_wr)
                r_load <= w_load_new[CNT_W-1:0];
            r_cnt     <= w_load_wr ? w_load_new[CNT_W-1:0] :
                         !w_tick ? r_cnt :
                         r_cnt != '0 ? r_cnt - ONE :
                         r_ctrl[2] ? r_load : r_cnt;
            r_expired <= w_expire || (r_expired && !w_stat_wr);
            r_irq     <= r_expired && r_ctrl[1];
        end
    end

    assign PRDATA  = (!PSEL || PWRITE || w_bad) ? 32'h0 :
                     w_off == 8'h00 ? {29'h0, r_ctrl} :
                     w_off == 8'h04 ? w_load32 :
                     w_off == 8'h08 ? w_cnt32 :
                     w_off == 8'h0C ? {31'h0, r_expired} : w_psc32;
    assign PREADY  = 1'b1;
    assign PSLVERR = w_acc && w_bad;
    assign o_irq   = r_irq;
    assign w_unused = ^{PADDR[31:8], PWDATA, w_load_new};
endmodule
